// File: rtl/palette_ram_nes.sv
// rtl/palette_ram_nes.sv - writable NES palette RAM with init fill, backdrop mirroring, optional grayscale (PALETTE_GRAYSCALE_EN)
module palette_ram_nes #(
    parameter int          AW         = 5,
    parameter int          DW         = 8,
    parameter logic [7:0]  INIT_COLOR = 8'h0F,
    parameter int          NES_MIRROR = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] ppu_addr,
    output logic [DW-1:0] ppu_dout,
    input  logic [AW-1:0] cpu_addr,
    input  logic          cpu_we,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_rdy,
    output logic [DW-1:0] cpu_rdata,
    output logic          init_busy,
    input  logic          grayscale
);

    localparam int            DEPTH     = 1 << AW;
    localparam logic [DW-1:0] INIT_VAL  = DW'(INIT_COLOR);
    localparam bit            MIRROR_ON = (NES_MIRROR != 0) && (AW == 5);

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t        state;
    state_t        state_nxt;
    logic [AW-1:0] cnt;
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] ppu_raw;
    logic [DW-1:0] ppu_next;

    // Sprite backdrop entries (0x10/0x14/0x18/0x1C) fold onto the background ones
    function automatic logic [AW-1:0] eff(input logic [AW-1:0] a);
        logic [AW-1:0] r;
        r = a;
        if (MIRROR_ON && a[AW-1] && (a[1:0] == 2'b00)) begin
            r[AW-1] = 1'b0;
        end
        return r;
    endfunction

    // State register and fill counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_INIT;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_INIT) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Next state and status outputs; RUN is only left through reset
    always_comb begin
        state_nxt = state;
        init_busy = 1'b1;
        cpu_rdy   = 1'b0;
        case (state)
            ST_INIT: begin
                if (&cnt) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                init_busy = 1'b0;
                cpu_rdy   = 1'b1;
            end
            default: state_nxt = ST_INIT;
        endcase
    end

    // Storage writes: init fill owns the array until RUN, then CPU writes are accepted
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == ST_INIT) begin
                mem[cnt] <= INIT_VAL;
            end else if (cpu_we && cpu_rdy) begin
                mem[eff(cpu_addr)] <= cpu_wdata;
            end
        end
    end

    // PPU read source: init colour while filling, otherwise the stored entry (old value on collision)
    always_comb begin
        ppu_raw = init_busy ? INIT_VAL : mem[eff(ppu_addr)];
    end

`ifdef PALETTE_GRAYSCALE_EN
    localparam logic [DW-1:0] GRAY_MASK = {DW{1'b1}} << 4;

    // Grayscale keeps only the luminance bits, applied before the register so latency is unchanged
    always_comb begin
        ppu_next = grayscale ? (ppu_raw & GRAY_MASK) : ppu_raw;
    end
`else
    logic unused_grayscale;
    assign unused_grayscale = grayscale;

    // Grayscale disabled: pass the read straight through
    always_comb begin
        ppu_next = ppu_raw;
    end
`endif

    // Registered PPU read port
    always_ff @(posedge clk) begin
        if (rst) begin
            ppu_dout <= INIT_VAL;
        end else begin
            ppu_dout <= ppu_next;
        end
    end

    // Registered CPU read port; holds its value except on an accepted read
    always_ff @(posedge clk) begin
        if (rst) begin
            cpu_rdata <= '0;
        end else if (cpu_rdy && !cpu_we) begin
            cpu_rdata <= mem[eff(cpu_addr)];
        end
    end

endmodule

// File: tb/tb_palette_ram_nes.sv
// tb/tb_palette_ram_nes.sv - scoreboard testbench for palette_ram_nes
module tb_palette_ram_nes;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] ppu_addr = '0;
    logic [7:0] ppu_dout;
    logic [4:0] cpu_addr = '0;
    logic       cpu_we = 1'b0;
    logic [7:0] cpu_wdata = '0;
    logic       cpu_rdy;
    logic [7:0] cpu_rdata;
    logic       init_busy;
    logic       grayscale = 1'b0;

    palette_ram_nes dut (
        .clk       (clk),
        .rst       (rst),
        .ppu_addr  (ppu_addr),
        .ppu_dout  (ppu_dout),
        .cpu_addr  (cpu_addr),
        .cpu_we    (cpu_we),
        .cpu_wdata (cpu_wdata),
        .cpu_rdy   (cpu_rdy),
        .cpu_rdata (cpu_rdata),
        .init_busy (init_busy),
        .grayscale (grayscale)
    );

    always #5 clk = ~clk;

    localparam int K_PPU  = 0;
    localparam int K_CPU  = 1;
    localparam int K_BUSY = 2;
    localparam int K_RDY  = 3;

    typedef struct {
        int         due;
        int         kind;
        logic [7:0] val;
        string      name;
    } exp_t;

    exp_t q[$];
    int   cyc    = 0;
    int   checks = 0;
    int   fails  = 0;
    exp_t e;
    logic [7:0] act;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compares every expectation that falls due this cycle, mid-cycle
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].due <= cyc) begin
            e = q.pop_front();
            case (e.kind)
                K_PPU:   act = ppu_dout;
                K_CPU:   act = cpu_rdata;
                K_BUSY:  act = {7'b0, init_busy};
                default: act = {7'b0, cpu_rdy};
            endcase
            checks = checks + 1;
            if (e.due != cyc || act !== e.val) begin
                fails = fails + 1;
                $display("FAIL %s: got %h expected %h (due %0d at %0d)", e.name, act, e.val, e.due, cyc);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_now(input int kind, input logic [7:0] val, input string name);
        q.push_back('{cyc, kind, val, name});
    endtask

    task automatic expect_next(input int kind, input logic [7:0] val, input string name);
        q.push_back('{cyc + 1, kind, val, name});
    endtask

    task automatic cpu_wr(input logic [4:0] a, input logic [7:0] d);
        cpu_we    = 1'b1;
        cpu_addr  = a;
        cpu_wdata = d;
        tick();
        cpu_we    = 1'b0;
    endtask

    task automatic cpu_rd(input logic [4:0] a, input logic [7:0] x, input string name);
        cpu_we   = 1'b0;
        cpu_addr = a;
        expect_next(K_CPU, x, name);
        tick();
    endtask

    task automatic ppu_rd(input logic [4:0] a, input logic [7:0] x, input string name);
        ppu_addr = a;
        expect_next(K_PPU, x, name);
        tick();
    endtask

    // Releases reset and sweeps the PPU address through the whole fill; optionally tries a write at cycle 3
    task automatic init_sweep(input bit try_write);
        rst = 1'b0;
        for (int i = 0; i < 32; i++) begin
            expect_now(K_BUSY, 8'h01, "init_busy_high");
            expect_now(K_RDY, 8'h00, "cpu_rdy_low");
            ppu_addr = 5'(i);
            expect_next(K_PPU, 8'h0F, "ppu_during_init");
            if (try_write && i == 3) begin
                cpu_we    = 1'b1;
                cpu_addr  = 5'h02;
                cpu_wdata = 8'h30;
            end else begin
                cpu_we    = 1'b0;
            end
            tick();
        end
        cpu_we = 1'b0;
        expect_now(K_BUSY, 8'h00, "init_busy_fall");
        expect_now(K_RDY, 8'h01, "cpu_rdy_rise");
        tick();
    endtask

    initial begin
        tick();
        expect_now(K_PPU, 8'h0F, "reset_ppu_dout");
        expect_now(K_CPU, 8'h00, "reset_cpu_rdata");
        expect_now(K_BUSY, 8'h01, "reset_init_busy");
        expect_now(K_RDY, 8'h00, "reset_cpu_rdy");
        tick();

        init_sweep(1'b1);

        cpu_wr(5'h05, 8'h27);
        cpu_rd(5'h05, 8'h27, "cpu_read_05");
        ppu_rd(5'h05, 8'h27, "ppu_read_05");

        cpu_wr(5'h10, 8'h15);
        cpu_rd(5'h00, 8'h15, "mirror_cpu_00");
        cpu_rd(5'h10, 8'h15, "mirror_cpu_10");
        ppu_rd(5'h00, 8'h15, "mirror_ppu_00");
        ppu_rd(5'h10, 8'h15, "mirror_ppu_10");

        cpu_wr(5'h11, 8'h3C);
        cpu_rd(5'h01, 8'h0F, "no_mirror_01");
        cpu_rd(5'h11, 8'h3C, "no_mirror_11");

        cpu_wr(5'h04, 8'h2A);
        ppu_rd(5'h14, 8'h2A, "mirror_ppu_14");

        ppu_addr = 5'h1D;
        expect_next(K_PPU, 8'h0F, "rbw_old_value");
        cpu_wr(5'h1D, 8'h37);
        ppu_rd(5'h1D, 8'h37, "rbw_new_value");

        cpu_rd(5'h02, 8'h0F, "init_write_dropped");

        cpu_wr(5'h03, 8'h27);
        grayscale = 1'b1;
`ifdef PALETTE_GRAYSCALE_EN
        ppu_rd(5'h03, 8'h20, "grayscale_ppu");
`else
        ppu_rd(5'h03, 8'h27, "grayscale_ignored_ppu");
`endif
        cpu_rd(5'h03, 8'h27, "grayscale_cpu_unmasked");
        grayscale = 1'b0;

        expect_next(K_CPU, 8'h27, "cpu_rdata_hold");
        cpu_wr(5'h06, 8'h11);

        rst = 1'b1;
        tick();
        expect_now(K_PPU, 8'h0F, "rerun_reset_ppu");
        expect_now(K_CPU, 8'h00, "rerun_reset_cpu");
        expect_now(K_BUSY, 8'h01, "rerun_reset_busy");
        expect_now(K_RDY, 8'h00, "rerun_reset_rdy");
        tick();
        init_sweep(1'b0);

        cpu_rd(5'h05, 8'h0F, "refill_05");
        cpu_rd(5'h10, 8'h0F, "refill_10");
        cpu_rd(5'h11, 8'h0F, "refill_11");
        ppu_rd(5'h1D, 8'h0F, "refill_ppu_1d");
        ppu_rd(5'h03, 8'h0F, "refill_ppu_03");

        for (int i = 0; i < 10 && q.size() > 0; i++) begin
            tick();
        end
        if (q.size() > 0) begin
            checks = checks + 1;
            fails  = fails + 1;
            $display("FAIL drain: %0d expectations left, required 0", q.size());
        end

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
